// File: rtl/lc3_mem_arb.sv
// Round-robin arbiter (CPU vs loader) in front of the single-port LC-3 memory, with loader lock and tagged read return.
// Optional LC3_ARB_WPROT_EN: CPU writes below 0x3000 are consumed without a memory write and flagged on cpu_werr.
module lc3_mem_arb #(
  parameter int AW      = 16,
  parameter int DW      = 16,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ldr_req,
  input  logic          ldr_we,
  input  logic [AW-1:0] ldr_addr,
  input  logic [DW-1:0] ldr_wdata,
  input  logic          ldr_lock,
  output logic          ldr_gnt,
  output logic          ldr_rvalid,
  output logic [DW-1:0] ldr_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
`ifdef LC3_ARB_WPROT_EN
  output logic          cpu_werr,
`endif
  output logic          busy
);

  typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               last_ldr_q, last_ldr_d;
  logic               lock_mode;
  logic               drop;
  logic               issue;
  logic               g_we;
  logic [AW-1:0]      g_addr;
  logic [DW-1:0]      g_wdata;
  logic               mem_we_q;
  logic [AW-1:0]      mem_addr_q;
  logic [DW-1:0]      mem_wdata_q;
  logic [MEM_LAT-1:0] tag_vld_q;
  logic [MEM_LAT-1:0] tag_id_q;
  logic [DW-1:0]      cpu_rdata_q;
  logic [DW-1:0]      ldr_rdata_q;

  // A dropped ldr_lock is seen in the same cycle, so that cycle arbitrates as ARB.
  assign lock_mode = (state_q == ST_LOCK) && ldr_lock;

  always_comb begin
    cpu_gnt    = 1'b0;
    ldr_gnt    = 1'b0;
    last_ldr_d = last_ldr_q;
    if (lock_mode) begin
      ldr_gnt = ldr_req;
    end else begin
      cpu_gnt = cpu_req && (!ldr_req || last_ldr_q);
      ldr_gnt = ldr_req && !cpu_gnt;
    end
    if (cpu_gnt) last_ldr_d = 1'b0;
    if (ldr_gnt) last_ldr_d = 1'b1;
    state_d = (lock_mode || (ldr_gnt && ldr_lock)) ? ST_LOCK : ST_ARB;
  end

`ifdef LC3_ARB_WPROT_EN
  logic werr_q;
  assign drop     = cpu_gnt && cpu_we && (cpu_addr < AW'(16'h3000));
  assign cpu_werr = werr_q;
  always_ff @(posedge clk) begin
    if (rst) werr_q <= 1'b0;
    else     werr_q <= drop;
  end
`else
  assign drop = 1'b0;
`endif

  assign issue   = (cpu_gnt || ldr_gnt) && !drop;
  assign g_we    = ldr_gnt ? ldr_we    : cpu_we;
  assign g_addr  = ldr_gnt ? ldr_addr  : cpu_addr;
  assign g_wdata = ldr_gnt ? ldr_wdata : cpu_wdata;

  assign mem_en    = issue;
  assign mem_we    = issue ? g_we    : mem_we_q;
  assign mem_addr  = issue ? g_addr  : mem_addr_q;
  assign mem_wdata = issue ? g_wdata : mem_wdata_q;

  // Tag id: 0 = CPU, 1 = loader; the last stage lines up with mem_rdata.
  assign cpu_rvalid = tag_vld_q[MEM_LAT-1] && !tag_id_q[MEM_LAT-1];
  assign ldr_rvalid = tag_vld_q[MEM_LAT-1] &&  tag_id_q[MEM_LAT-1];
  assign cpu_rdata  = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ldr_rdata  = ldr_rvalid ? mem_rdata : ldr_rdata_q;
  assign busy       = (state_q == ST_LOCK);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_ARB;
      last_ldr_q  <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_vld_q   <= '0;
      tag_id_q    <= '0;
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      last_ldr_q <= last_ldr_d;
      if (issue) begin
        mem_we_q    <= g_we;
        mem_addr_q  <= g_addr;
        mem_wdata_q <= g_wdata;
      end
      tag_vld_q[0] <= issue && !g_we;
      tag_id_q[0]  <= ldr_gnt;
      for (int i = 1; i < MEM_LAT; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_id_q[i]  <= tag_id_q[i-1];
      end
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (ldr_rvalid) ldr_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_lc3_mem_arb.sv
// Bench for lc3_mem_arb: a MEM_LAT=1 instance carries the scoreboarded traffic, a MEM_LAT=3
// instance on the same inputs covers reset with a read in flight.
module tb_lc3_mem_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, ldr_req = 1'b0, ldr_we = 1'b0, ldr_lock = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0, ldr_addr = '0, ldr_wdata = '0;

  logic        cpu_gnt, cpu_rvalid, ldr_gnt, ldr_rvalid, mem_en, mem_we, busy;
  logic [15:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        c3_gnt, c3_rvalid, l3_gnt, l3_rvalid, m3_en, m3_we, busy3;
  logic [15:0] c3_rdata, l3_rdata, m3_addr, m3_wdata, m3_rdata;
`ifdef LC3_ARB_WPROT_EN
  logic        cpu_werr, werr3;
`endif

  always #5 clk = ~clk;

  lc3_mem_arb #(.AW(16), .DW(16), .MEM_LAT(1)) u1 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(ldr_gnt), .ldr_rvalid(ldr_rvalid), .ldr_rdata(ldr_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
`ifdef LC3_ARB_WPROT_EN
    .cpu_werr(cpu_werr),
`endif
    .busy(busy)
  );

  lc3_mem_arb #(.AW(16), .DW(16), .MEM_LAT(3)) u3 (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(c3_gnt), .cpu_rvalid(c3_rvalid), .cpu_rdata(c3_rdata),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_lock(ldr_lock), .ldr_gnt(l3_gnt), .ldr_rvalid(l3_rvalid), .ldr_rdata(l3_rdata),
    .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
    .mem_rdata(m3_rdata),
`ifdef LC3_ARB_WPROT_EN
    .cpu_werr(werr3),
`endif
    .busy(busy3)
  );

  // Memory models: latency 1 and latency 3.
  logic [15:0] mem1 [0:65535];
  logic [15:0] mem3 [0:65535];
  logic [15:0] rp1 = '0;
  logic [15:0] rp3 [0:2] = '{16'h0, 16'h0, 16'h0};
  assign mem_rdata = rp1;
  assign m3_rdata  = rp3[2];

  always @(posedge clk) begin
    if (mem_en && mem_we) mem1[mem_addr] <= mem_wdata;
    if (mem_en && !mem_we) rp1 <= mem1[mem_addr];
    if (m3_en && m3_we) mem3[m3_addr] <= m3_wdata;
    rp3[0] <= (m3_en && !m3_we) ? mem3[m3_addr] : 16'h0;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] ref_mem [0:65535];
  logic [15:0] image [0:20] = '{
    16'h5260, 16'h5020, 16'h2C12, 16'h2A12, 16'h1DA0, 16'h0406, 16'h6180, 16'h1240,
    16'h1DA1, 16'h1B7F, 16'h0BFB, 16'h3406, 16'hF025, 16'h3100, 16'h0005, 16'h0003,
    16'h0007, 16'h0001, 16'h0002, 16'h0004, 16'h0000
  };

  typedef struct {
    bit          id;
    logic [15:0] data;
    int          cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t e;

  // Scoreboard consumer for read returns of the latency-1 instance.
  always @(negedge clk) begin
    if (!rst) begin
      if (cpu_rvalid || ldr_rvalid) begin
        vectors++;
        if (sbq.size() == 0) begin
          miscompares++;
          $display("FAIL rvalid_unexpected: cpu_rvalid=%0b ldr_rvalid=%0b cyc=%0d, no read outstanding",
                   cpu_rvalid, ldr_rvalid, cyc);
        end else begin
          e = sbq.pop_front();
          if ({cpu_rvalid, ldr_rvalid, cyc} !== {!e.id, e.id, e.cyc} ||
              (e.id ? ldr_rdata : cpu_rdata) !== e.data) begin
            miscompares++;
            $display("FAIL rvalid_return: got cpu_rv=%0b ldr_rv=%0b cyc=%0d data=%h, want id=%0d cyc=%0d data=%h",
                     cpu_rvalid, ldr_rvalid, cyc, e.id ? ldr_rdata : cpu_rdata, e.id, e.cyc, e.data);
          end
        end
      end
      if (cpu_gnt && ldr_gnt) begin
        vectors++;
        miscompares++;
        $display("FAIL double_grant: cpu_gnt=1 ldr_gnt=1 at cyc=%0d, want at most one", cyc);
      end
    end
  end

  task automatic idle();
    cpu_req = 1'b0; cpu_we = 1'b0; ldr_req = 1'b0; ldr_we = 1'b0; ldr_lock = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    idle();
    rst = 1'b1;
    repeat (n) next_cycle();
    rst = 1'b0;
    sbq.delete();
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl: gnt/rvalid/en/we/busy = %b, want 0000000",
               {cpu_gnt, ldr_gnt, cpu_rvalid, ldr_rvalid, mem_en, mem_we, busy});
    end
    vectors++;
    if ({mem_addr, mem_wdata, cpu_rdata, ldr_rdata} !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_data: addr=%h wdata=%h cpu_rdata=%h ldr_rdata=%h, want all 0",
               mem_addr, mem_wdata, cpu_rdata, ldr_rdata);
    end
    next_cycle();
  endtask

  task automatic test_loader_image();
    for (int i = 0; i < 21; i++) begin
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_addr = 16'h3000 + 16'(i); ldr_wdata = image[i];
      ref_mem[16'h3000 + 16'(i)] = image[i];
      @(negedge clk);
      vectors++;
      if ({ldr_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata} !==
          {4'b1011, 16'h3000 + 16'(i), image[i]}) begin
        miscompares++;
        $display("FAIL loader_write[%0d]: gnt l/c=%0b%0b en=%0b we=%0b addr=%h data=%h, want 1 0 1 1 %h %h",
                 i, ldr_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata, 16'h3000 + 16'(i), image[i]);
      end
      next_cycle();
    end
    idle();
    @(negedge clk);
    vectors++;
    if (mem_en !== 1'b0 || ldr_rvalid !== 1'b0) begin
      miscompares++;
      $display("FAIL loader_idle: mem_en=%0b ldr_rvalid=%0b, want 0 0", mem_en, ldr_rvalid);
    end
    for (int i = 0; i < 21; i++) begin
      vectors++;
      if (mem1[16'h3000 + 16'(i)] !== image[i]) begin
        miscompares++;
        $display("FAIL image_word[%0d]: mem=%h, want %h", i, mem1[16'h3000 + 16'(i)], image[i]);
      end
    end
    next_cycle();
  endtask

  task automatic test_cpu_read();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3000;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr} !== {4'b1010, 16'h3000}) begin
      miscompares++;
      $display("FAIL cpu_read_issue: gnt c/l=%0b%0b en=%0b we=%0b addr=%h, want 1 0 1 0 3000",
               cpu_gnt, ldr_gnt, mem_en, mem_we, mem_addr);
    end
    sbq.push_back('{id: 1'b0, data: ref_mem[16'h3000], cyc: cyc + 1});
    next_cycle();
    idle();
    @(negedge clk);
    vectors++;
    if ({cpu_rvalid, ldr_rvalid, cpu_rdata} !== {2'b10, image[0]}) begin
      miscompares++;
      $display("FAIL cpu_read_return: cpu_rv=%0b ldr_rv=%0b rdata=%h, want 1 0 %h",
               cpu_rvalid, ldr_rvalid, cpu_rdata, image[0]);
    end
    next_cycle();
    @(negedge clk);
    vectors++;
    if ({cpu_rvalid, cpu_rdata} !== {1'b0, image[0]}) begin
      miscompares++;
      $display("FAIL cpu_read_pulse: cpu_rv=%0b rdata=%h, want 0 %h (held)", cpu_rvalid, cpu_rdata, image[0]);
    end
    next_cycle();
  endtask

  task automatic test_alternate();
    logic [15:0] ca, la;
    bit          exp_ldr;
    do_reset(1);
    ca = 16'h3000; la = 16'h300A;
    for (int k = 0; k < 8; k++) begin
      exp_ldr = (k % 2) == 1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = ca;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = la;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, ldr_gnt, mem_addr} !== {!exp_ldr, exp_ldr, exp_ldr ? la : ca}) begin
        miscompares++;
        $display("FAIL alternate[%0d]: gnt c/l=%0b%0b addr=%h, want %0b%0b %h",
                 k, cpu_gnt, ldr_gnt, mem_addr, !exp_ldr, exp_ldr, exp_ldr ? la : ca);
      end
      sbq.push_back('{id: exp_ldr, data: ref_mem[exp_ldr ? la : ca], cyc: cyc + 1});
      next_cycle();
      if (exp_ldr) la = la + 16'h1;
      else         ca = ca + 16'h1;
    end
    idle();
    repeat (2) next_cycle();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL alternate_drain: %0d reads still outstanding, want 0", sbq.size());
    end
  endtask

  task automatic test_lock();
    do_reset(1);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3001;
    @(negedge clk);
    vectors++;
    if (cpu_gnt !== 1'b1) begin
      miscompares++;
      $display("FAIL lock_pre: cpu_gnt=%0b, want 1", cpu_gnt);
    end
    sbq.push_back('{id: 1'b0, data: ref_mem[16'h3001], cyc: cyc + 1});
    next_cycle();
    cpu_we = 1'b1; cpu_addr = 16'h3200; cpu_wdata = 16'hBEEF;
    for (int i = 1; i <= 5; i++) begin
      ldr_req = 1'b1; ldr_we = 1'b1; ldr_lock = 1'b1;
      ldr_addr = 16'h3100 + 16'(i); ldr_wdata = 16'hA000 + 16'(i);
      ref_mem[ldr_addr] = ldr_wdata;
      @(negedge clk);
      vectors++;
      if ({cpu_gnt, ldr_gnt} !== 2'b01 || (i >= 2 && busy !== 1'b1)) begin
        miscompares++;
        $display("FAIL lock_hold[%0d]: gnt c/l=%0b%0b busy=%0b, want 0 1 busy=%0b",
                 i, cpu_gnt, ldr_gnt, busy, i >= 2);
      end
      next_cycle();
    end
    ldr_lock = 1'b0; ldr_addr = 16'h3106; ldr_wdata = 16'hA006;
    ref_mem[16'h3200] = 16'hBEEF;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ldr_gnt, mem_addr, mem_wdata} !== {2'b10, 16'h3200, 16'hBEEF}) begin
      miscompares++;
      $display("FAIL lock_release: gnt c/l=%0b%0b addr=%h data=%h, want 1 0 3200 beef",
               cpu_gnt, ldr_gnt, mem_addr, mem_wdata);
    end
    next_cycle();
    cpu_req = 1'b0;
    ref_mem[16'h3106] = 16'hA006;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, ldr_gnt, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL lock_after: gnt c/l=%0b%0b busy=%0b, want 0 1 0", cpu_gnt, ldr_gnt, busy);
    end
    next_cycle();
    idle();
    next_cycle();
    vectors++;
    if (mem1[16'h3200] !== 16'hBEEF || mem1[16'h3105] !== 16'hA005) begin
      miscompares++;
      $display("FAIL lock_mem: mem[3200]=%h mem[3105]=%h, want beef a005", mem1[16'h3200], mem1[16'h3105]);
    end
  endtask

  task automatic test_reset_inflight();
    idle();
    repeat (4) next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3002;
    @(negedge clk);
    vectors++;
    if ({c3_gnt, m3_en} !== 2'b11) begin
      miscompares++;
      $display("FAIL inflight_issue: lat3 gnt=%0b en=%0b, want 1 1", c3_gnt, m3_en);
    end
    next_cycle();
    do_reset(1);
    @(negedge clk);
    vectors++;
    if ({c3_gnt, l3_gnt, c3_rvalid, l3_rvalid, m3_en, m3_we, busy3, m3_addr, m3_wdata, c3_rdata} !== 55'h0) begin
      miscompares++;
      $display("FAIL inflight_reset_vals: ctrl=%b addr=%h wdata=%h rdata=%h, want all 0",
               {c3_gnt, l3_gnt, c3_rvalid, l3_rvalid, m3_en, m3_we, busy3}, m3_addr, m3_wdata, c3_rdata);
    end
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if (c3_rvalid !== 1'b0 || l3_rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL inflight_discard[%0d]: lat3 cpu_rv=%0b ldr_rv=%0b, want 0 0", i, c3_rvalid, l3_rvalid);
      end
      next_cycle();
      @(negedge clk);
    end
    next_cycle();
  endtask

`ifdef LC3_ARB_WPROT_EN
  task automatic test_wprot();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2FFF; cpu_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, mem_en, cpu_werr} !== 3'b100) begin
      miscompares++;
      $display("FAIL wprot_drop: gnt=%0b en=%0b werr=%0b, want 1 0 0", cpu_gnt, mem_en, cpu_werr);
    end
    next_cycle();
    idle();
    @(negedge clk);
    vectors++;
    if (cpu_werr !== 1'b1) begin
      miscompares++;
      $display("FAIL wprot_werr: werr=%0b, want 1", cpu_werr);
    end
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h3000; cpu_wdata = 16'h1357;
    ref_mem[16'h3000] = 16'h1357;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, mem_en, mem_we, cpu_werr, mem_addr} !== {4'b1110, 16'h3000}) begin
      miscompares++;
      $display("FAIL wprot_pass: gnt=%0b en=%0b we=%0b werr=%0b addr=%h, want 1 1 1 0 3000",
               cpu_gnt, mem_en, mem_we, cpu_werr, mem_addr);
    end
    next_cycle();
    idle();
    @(negedge clk);
    vectors++;
    if (cpu_werr !== 1'b0 || mem1[16'h3000] !== 16'h1357) begin
      miscompares++;
      $display("FAIL wprot_after: werr=%0b mem[3000]=%h, want 0 1357", cpu_werr, mem1[16'h3000]);
    end
    next_cycle();
  endtask
`else
  task automatic test_wprot();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h2FFF; cpu_wdata = 16'h1234;
    @(negedge clk);
    vectors++;
    if ({cpu_gnt, mem_en, mem_we, mem_addr} !== {3'b111, 16'h2FFF}) begin
      miscompares++;
      $display("FAIL nowprot_write: gnt=%0b en=%0b we=%0b addr=%h, want 1 1 1 2fff",
               cpu_gnt, mem_en, mem_we, mem_addr);
    end
    next_cycle();
    idle();
    @(negedge clk);
    vectors++;
    if (mem1[16'h2FFF] !== 16'h1234) begin
      miscompares++;
      $display("FAIL nowprot_mem: mem[2fff]=%h, want 1234", mem1[16'h2FFF]);
    end
    next_cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_loader_image();
    test_cpu_read();
    test_alternate();
    test_lock();
    test_reset_inflight();
    test_wprot();
    repeat (3) next_cycle();
    vectors++;
    if (sbq.size() != 0) begin
      miscompares++;
      $display("FAIL final_drain: %0d reads never returned, want 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
